// File: rtl/hdmi_in_box_downscale_if.sv
`default_nettype none
// ============================================================================
// hdmi_in_box_downscale_if
//   Pixel-stream bundle between the HDMI receiver side and the box downscaler.
//   Revision: 1.0
// ============================================================================
interface hdmi_in_box_downscale_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 3
);
  logic [CH*DATA_W-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_vs;
  logic [CH*DATA_W-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_sof;
  logic                 data_out_eol;

  modport master (
    output data_in, data_in_valid, data_in_vs,
    input  data_out, data_out_valid, data_out_sof, data_out_eol
  );

  modport slave (
    input  data_in, data_in_valid, data_in_vs,
    output data_out, data_out_valid, data_out_sof, data_out_eol
  );
endinterface
`default_nettype wire

// File: rtl/hdmi_in_box_downscale.sv
`default_nettype none
// ============================================================================
// hdmi_in_box_downscale
//   Averages each KxK pixel block (K = 2^SCALE_LOG2) into one output pixel.
//   Optional macro HDMI_DS_ROUND_EN: round-half-up instead of truncation.
//   Revision: 1.0
// ============================================================================
module hdmi_in_box_downscale #(
  parameter int IN_WIDTH   = 1920,
  parameter int SCALE_LOG2 = 1,
  parameter int DATA_W     = 8,
  parameter int CH         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  hdmi_in_box_downscale_if.slave bus
);
  localparam int K      = 1 << SCALE_LOG2;
  localparam int OUT_W  = IN_WIDTH / K;
  localparam int SH     = 2 * SCALE_LOG2;
  localparam int PW     = DATA_W + SH;
  localparam int COL_W  = $clog2(IN_WIDTH);
  localparam int OCOL_W = COL_W - SCALE_LOG2;

  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IN_WIDTH - 1);
  localparam logic [SCALE_LOG2-1:0] LAST_PH   = SCALE_LOG2'(K - 1);
  localparam logic [OCOL_W-1:0]     LAST_OCOL = OCOL_W'(OUT_W - 1);

  if ((IN_WIDTH % K) != 0 || OUT_W < 2) begin : g_bad_width
    $error("IN_WIDTH must be a multiple of K with at least two output columns");
  end
  if (SCALE_LOG2 < 1 || SCALE_LOG2 > 3) begin : g_bad_scale
    $error("SCALE_LOG2 must be in 1..3");
  end

  logic [COL_W-1:0]      in_col;
  logic [SCALE_LOG2-1:0] row_ph;
  logic [COL_W-1:0]      cur_col;
  logic [SCALE_LOG2-1:0] cur_row;
  logic [SCALE_LOG2-1:0] h_ph;
  logic [OCOL_W-1:0]     cur_ocol;
  logic                  accept;
  logic                  grp_first;
  logic                  grp_last;

  logic [PW-1:0]         hsum [CH];
  logic [CH*PW-1:0]      lb_mem [OUT_W];
  logic [CH*PW-1:0]      lb_rd;
  logic [CH*PW-1:0]      tot;
  logic [CH*DATA_W-1:0]  avg;
  logic [PW-1:0]         t_ch;
  logic [PW-1:0]         r_ch;

  logic                  c1_valid;
  logic [SCALE_LOG2-1:0] c1_row;
  logic [OCOL_W-1:0]     c1_ocol;
  logic                  c1_emit;
  logic                  sof_armed;
  logic [CH*DATA_W-1:0]  out_data;
  logic                  out_valid;
  logic                  out_sof;
  logic                  out_eol;

  // A frame-start strobe re-bases the incoming pixel to column 0, row 0.
  assign accept    = bus.data_in_valid;
  assign cur_col   = bus.data_in_vs ? '0 : in_col;
  assign cur_row   = bus.data_in_vs ? '0 : row_ph;
  assign h_ph      = cur_col[SCALE_LOG2-1:0];
  assign cur_ocol  = cur_col[COL_W-1:SCALE_LOG2];
  assign grp_first = accept && (h_ph == '0);
  assign grp_last  = accept && (h_ph == LAST_PH);
  assign c1_emit   = c1_valid && (c1_row == LAST_PH);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_col <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (cur_col == LAST_COL) begin
        in_col <= '0;
        row_ph <= cur_row + SCALE_LOG2'(1);
      end else begin
        in_col <= cur_col + COL_W'(1);
        row_ph <= cur_row;
      end
    end else if (bus.data_in_vs) begin
      in_col <= '0;
      row_ph <= '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        hsum[c] <= '0;
      end else if (accept) begin
        hsum[c] <= (grp_first ? '0 : hsum[c]) + PW'(bus.data_in[(CH-1-c)*DATA_W +: DATA_W]);
      end else if (bus.data_in_vs) begin
        hsum[c] <= '0;
      end
    end
  end

  // Write of column c and read of column c+1 can share a cycle; addresses differ.
  always_ff @(posedge clk) begin
    if (c1_valid && (c1_row != LAST_PH)) begin
      lb_mem[c1_ocol] <= tot;
    end
    if (grp_first) begin
      lb_rd <= lb_mem[cur_ocol];
    end
  end

  always_comb begin
    tot  = '0;
    avg  = '0;
    t_ch = '0;
    r_ch = '0;
    for (int c = 0; c < CH; c++) begin
      t_ch = hsum[c] + ((c1_row == '0) ? '0 : lb_rd[(CH-1-c)*PW +: PW]);
`ifdef HDMI_DS_ROUND_EN
      r_ch = t_ch + PW'(1 << (SH - 1));
`else
      r_ch = t_ch;
`endif
      tot[(CH-1-c)*PW +: PW]         = t_ch;
      avg[(CH-1-c)*DATA_W +: DATA_W] = DATA_W'(r_ch >> SH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c1_valid  <= 1'b0;
      c1_row    <= '0;
      c1_ocol   <= '0;
      sof_armed <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      c1_valid <= grp_last;
      if (grp_last) begin
        c1_row  <= cur_row;
        c1_ocol <= cur_ocol;
      end
      out_valid <= c1_emit;
      out_sof   <= c1_emit && sof_armed;
      out_eol   <= c1_emit && (c1_ocol == LAST_OCOL);
      if (c1_emit) begin
        out_data <= avg;
      end
      if (bus.data_in_vs) begin
        sof_armed <= 1'b1;
      end else if (c1_emit) begin
        sof_armed <= 1'b0;
      end
    end
  end

  assign bus.data_out       = out_data;
  assign bus.data_out_valid = out_valid;
  assign bus.data_out_sof   = out_sof;
  assign bus.data_out_eol   = out_eol;
endmodule
`default_nettype wire

// File: tb/tb_hdmi_in_box_downscale.sv
`default_nettype none
// ============================================================================
// tb_hdmi_in_box_downscale
//   Random and directed frames on a K=2/CH=3 and a K=4/CH=1 instance, checked
//   against a block-average reference model.  Revision: 1.0
// ============================================================================
module tb_hdmi_in_box_downscale;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_in_box_downscale_if #(.DATA_W(8), .CH(3)) bus0 ();
  hdmi_in_box_downscale_if #(.DATA_W(8), .CH(1)) bus1 ();

  hdmi_in_box_downscale #(.IN_WIDTH(8), .SCALE_LOG2(1), .DATA_W(8), .CH(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  hdmi_in_box_downscale #(.IN_WIDTH(16), .SCALE_LOG2(2), .DATA_W(8), .CH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    int          due;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          last_rst = 1'b0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [23:0] obs0[$];
  logic [23:0] obs1[$];
  int          m_col [2];
  int          m_row [2];
  bit          m_sof [2];
  int          px [2][4][16][3];

`ifdef HDMI_DS_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  function automatic int k_of(input int d);  return d ? 4 : 2;   endfunction
  function automatic int w_of(input int d);  return d ? 16 : 8;  endfunction
  function automatic int ch_of(input int d); return d ? 1 : 3;   endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: store every accepted pixel at (row, col); when a block's last pixel
  // arrives on the last row of the band, average the KxK block directly.
  task automatic model_edge(input int d, input bit vs, input bit v, input logic [23:0] din);
    int k, w, nc, s;
    exp_t e;
    k = k_of(d); w = w_of(d); nc = ch_of(d);
    if (vs) begin
      m_col[d] = 0; m_row[d] = 0; m_sof[d] = 1'b1;
    end
    if (v) begin
      for (int c = 0; c < nc; c++)
        px[d][m_row[d]][m_col[d]][c] = int'((din >> ((nc-1-c)*8)) & 24'hFF);
      if (m_row[d] == k-1 && (m_col[d] % k) == k-1) begin
        e.data = '0;
        for (int c = 0; c < nc; c++) begin
          s = 0;
          for (int r = 0; r < k; r++)
            for (int x = m_col[d]-k+1; x <= m_col[d]; x++)
              s += px[d][r][x][c];
          s = ROUND ? (s + k*k/2) / (k*k) : s / (k*k);
          e.data |= 24'(s) << ((nc-1-c)*8);
        end
        e.sof = m_sof[d];
        m_sof[d] = 1'b0;
        e.eol = (m_col[d] / k) == (w / k - 1);
        e.due = cyc + 1;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      m_col[d]++;
      if (m_col[d] == w) begin
        m_col[d] = 0;
        m_row[d] = (m_row[d] + 1) % k;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    last_rst = rst;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_col[d] = 0; m_row[d] = 0; m_sof[d] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      model_edge(0, bus0.data_in_vs, bus0.data_in_valid, bus0.data_in);
      model_edge(1, bus1.data_in_vs, bus1.data_in_valid, {16'h0, bus1.data_in});
    end
  end

  task automatic check_port(input int d, input logic v, input logic sof, input logic eol,
                            input logic [23:0] dat);
    exp_t  e;
    bit    have;
    string p;
    p = d ? "k4" : "k2";
    have = 1'b0;
    if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
    if (v === 1'b1) begin
      if (!have) begin
        check_eq({p, "_spurious_valid"}, {31'b0, v}, 32'd0);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check_eq({p, "_latency"}, cyc, e.due);
        check_eq({p, "_data"}, {8'h0, dat}, {8'h0, e.data});
        check_eq({p, "_sof"}, {31'b0, sof}, {31'b0, e.sof});
        check_eq({p, "_eol"}, {31'b0, eol}, {31'b0, e.eol});
        if (d == 0) obs0.push_back(dat); else obs1.push_back(dat);
      end
    end else if (have && e.due <= cyc) begin
      check_eq({p, "_missing_valid"}, {31'b0, v}, 32'd1);
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (last_rst) begin
      check_eq("rst_k2_out", {bus0.data_out, bus0.data_out_valid, bus0.data_out_sof,
                              bus0.data_out_eol}, 32'd0);
      check_eq("rst_k4_out", {bus1.data_out, bus1.data_out_valid, bus1.data_out_sof,
                              bus1.data_out_eol}, 32'd0);
    end else begin
      check_port(0, bus0.data_out_valid, bus0.data_out_sof, bus0.data_out_eol, bus0.data_out);
      check_port(1, bus1.data_out_valid, bus1.data_out_sof, bus1.data_out_eol,
                 {16'h0, bus1.data_out});
    end
  end

  task automatic drive(input int d, input bit vs, input bit v, input logic [23:0] pix);
    if (d == 0) begin
      bus0.data_in_vs = vs; bus0.data_in_valid = v; bus0.data_in = pix;
    end else begin
      bus1.data_in_vs = vs; bus1.data_in_valid = v; bus1.data_in = pix[7:0];
    end
    @(posedge clk);
    #1;
    bus0.data_in_vs = 1'b0; bus0.data_in_valid = 1'b0;
    bus1.data_in_vs = 1'b0; bus1.data_in_valid = 1'b0;
  endtask

  // mode: 0 constant, 1 random, 2 column index, 3 rounding corner block
  task automatic send_pixels(input int d, input int n, input int mode, input logic [23:0] val,
                             input int gap_pct, input bit vs_first);
    int w, col, row;
    logic [23:0] pix;
    w = w_of(d);
    for (int i = 0; i < n; i++) begin
      col = i % w;
      row = i / w;
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++)
        drive(d, 1'b0, 1'b0, 24'($urandom));
      case (mode)
        0:       pix = val;
        1:       pix = 24'($urandom);
        2:       pix = {3{8'(col)}};
        default: pix = (col < 2 && !(row == 0 && col == 0)) ? 24'h010101 : 24'h0;
      endcase
      drive(d, vs_first && (i == 0), 1'b1, pix);
    end
  endtask

  task automatic send_frame(input int d, input int mode, input logic [23:0] val,
                            input int gap_pct, input bit vs_with_pix);
    if (!vs_with_pix) drive(d, 1'b1, 1'b0, 24'h0);
    send_pixels(d, w_of(d) * k_of(d), mode, val, gap_pct, vs_with_pix);
    repeat (4) drive(d, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic check_obs0(input string tag, input int n, input logic [23:0] want);
    logic [23:0] v;
    check_eq({tag, "_count"}, obs0.size(), n);
    for (int i = 0; i < obs0.size(); i++) begin
      v = obs0[i];
      check_eq({tag, "_px"}, {8'h0, v}, {8'h0, want});
    end
    obs0.delete();
  endtask

  initial begin
    logic [23:0] v;
    int          grad [4];
    bus0.data_in = '0; bus0.data_in_valid = 1'b0; bus0.data_in_vs = 1'b0;
    bus1.data_in = '0; bus1.data_in_valid = 1'b0; bus1.data_in_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) drive(0, 1'b0, 1'b0, 24'h0);

    send_frame(0, 0, 24'h646464, 0, 1'b0);
    check_obs0("const", 4, 24'h646464);

    send_frame(0, 3, 24'h0, 0, 1'b0);
    check_eq("round_count", obs0.size(), 4);
    if (obs0.size() > 0) begin
      v = obs0[0];
      check_eq("round_r", {24'h0, v[23:16]}, ROUND ? 32'd1 : 32'd0);
    end
    obs0.delete();
    send_frame(0, 0, 24'hFFFFFF, 0, 1'b0);
    check_obs0("all255", 4, 24'hFFFFFF);

    send_frame(0, 0, 24'h646464, 40, 1'b0);
    check_obs0("gaps", 4, 24'h646464);

    send_pixels(0, 5, 1, 24'h0, 0, 1'b1);
    send_frame(0, 0, 24'h101010, 0, 1'b0);
    check_obs0("vs_mid", 4, 24'h101010);

    send_pixels(0, 12, 1, 24'h0, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs0.delete();
    send_frame(0, 0, 24'h202020, 0, 1'b0);
    check_obs0("after_rst", 4, 24'h202020);

    for (int f = 0; f < 6; f++) send_frame(0, 1, 24'h0, 25, 1'($urandom_range(1)));
    drive(0, 1'b1, 1'b0, 24'h0);
    send_pixels(0, 6, 1, 24'h0, 10, 1'b0);
    send_pixels(0, 16, 1, 24'h0, 10, 1'b0);
    repeat (4) drive(0, 1'b0, 1'b0, 24'h0);
    send_frame(0, 1, 24'h0, 0, 1'b1);
    obs0.delete();

    grad = ROUND ? '{2, 6, 10, 14} : '{1, 5, 9, 13};
    send_frame(1, 2, 24'h0, 0, 1'b0);
    check_eq("grad_count", obs1.size(), 4);
    for (int i = 0; i < obs1.size() && i < 4; i++) begin
      v = obs1[i];
      check_eq("grad_px", {8'h0, v}, grad[i]);
    end
    obs1.delete();
    for (int f = 0; f < 3; f++) send_frame(1, 1, 24'h0, 20, 1'($urandom_range(1)));

    repeat (8) drive(0, 1'b0, 1'b0, 24'h0);
    check_eq("k2_drained", q0.size(), 0);
    check_eq("k4_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
